// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N:1 round-robin stream mux with registered output stage
// Optional packet lock (in_last/out_last) enabled by defining RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux #(
   parameter  int N     = 4,
   parameter  int W     = 8,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_valid,
   input  logic [N*W-1:0]   in_data,
   output logic [N-1:0]     in_ready,
`ifdef RR_STREAM_MUX_LOCK_EN
   input  logic [N-1:0]     in_last,
   output logic             out_last,
`endif
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   input  logic             out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic             load;
   logic             found;
   logic [N-1:0]     eff_valid;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic [W-1:0]     sel_data;
   logic [SEL_W-1:0] ptr_adv;
   int               idx;

`ifdef RR_STREAM_MUX_LOCK_EN
   logic             lock_q,    lock_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic             out_last_q, out_last_d;
   logic             sel_last;
`endif

   assign load = ~out_valid_q | out_ready;

   // While a packet is in flight only the locked channel may compete.
   always_comb begin
      eff_valid = in_valid;
`ifdef RR_STREAM_MUX_LOCK_EN
      if (lock_q) begin
         eff_valid = '0;
         eff_valid[lock_ch_q] = in_valid[lock_ch_q];
      end
`endif
   end

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && eff_valid[idx]) begin
            found     = 1'b1;
            grant_idx = SEL_W'(idx);
         end
      end
      grant = '0;
      if (found) grant[grant_idx] = 1'b1;
   end

   // Mask-and-OR select keeps the data path free of a priority chain.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
      end
   end

`ifdef RR_STREAM_MUX_LOCK_EN
   assign sel_last = |(in_last & grant);
`endif

   assign in_ready = grant & {N{load}};
   assign ptr_adv  = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef RR_STREAM_MUX_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
      out_last_d  = out_last_q;
`endif
      if (load) begin
         if (found) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
            out_last_d  = sel_last;
            lock_d      = ~sel_last;
            lock_ch_d   = grant_idx;
            if (sel_last) ptr_d = ptr_adv;
`else
            ptr_d       = ptr_adv;
`endif
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef RR_STREAM_MUX_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
`ifdef RR_STREAM_MUX_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - self-checking bench for rr_stream_mux (directed + random vs model)
module tb_rr_stream_mux;
   localparam int N     = 4;
   localparam int W     = 8;
   localparam int SEL_W = 2;
`ifdef RR_STREAM_MUX_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     in_valid = '0;
   logic [N*W-1:0]   in_data  = '0;
   logic [N-1:0]     in_last  = '1;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_last;
   logic             out_ready = 1'b1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_stream_mux #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef RR_STREAM_MUX_LOCK_EN
      .in_last(in_last), .out_last(out_last),
`endif
      .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .out_ready(out_ready)
   );
`ifndef RR_STREAM_MUX_LOCK_EN
   assign out_last = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: winner is the first valid channel scanning from ptr (mod N).
   logic          m_valid;
   logic [W-1:0]  m_data;
   int            m_sel, m_ptr, m_lock_ch, m_acc, m_win;
   logic          m_last, m_lock, m_load;
   logic [N-1:0]  m_ready;

   function automatic int pick(input logic [N-1:0] v, input int p, input logic lk, input int lch);
      if (lk) return v[lch] ? lch : -1;
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always_comb begin
      m_load  = !m_valid || out_ready;
      m_win   = pick(in_valid, m_ptr, LOCK && m_lock, m_lock_ch);
      m_ready = (m_load && m_win >= 0) ? N'(1 << m_win) : '0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0; m_data <= '0; m_sel <= 0; m_ptr <= 0;
         m_last <= 1'b0; m_lock <= 1'b0; m_lock_ch <= 0; m_acc <= -1;
      end else begin
         m_acc <= -1;
         if (m_load) begin
            if (m_win >= 0) begin
               m_valid <= 1'b1;
               m_data  <= in_data[m_win*W +: W];
               m_sel   <= m_win;
               m_last  <= in_last[m_win];
               m_acc   <= m_win;
               if (!LOCK || in_last[m_win]) m_ptr <= (m_win + 1) % N;
               if (LOCK) begin
                  m_lock    <= !in_last[m_win];
                  m_lock_ch <= m_win;
               end
            end else begin
               m_valid <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'(m_ready));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_sel", 32'(out_sel), 32'(m_sel));
            if (LOCK) chk("out_last", 32'(out_last), 32'(m_last));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_sel", 32'(out_sel), 0);
      rst = 1'b0;

      // single channel
      cyc();
      in_valid = 4'b0100;
      in_data[2*W +: W] = 8'hC3;
      #1 chk("single_ready", 32'(in_ready), 32'b0100);
      cyc();
      in_valid = '0;
      #1;
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'hC3);
      chk("single_sel", 32'(out_sel), 2);

      // asynchronous reset while holding a word
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(out_valid), 0);
      chk("async_data", 32'(out_data), 0);
      chk("async_sel", 32'(out_sel), 0);
      rst = 1'b0;

      // all channels valid: fair rotation at full rate
      in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid = '1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         #1;
         chk("rot_valid", 32'(out_valid), 1);
         chk("rot_sel", 32'(out_sel), 32'(i % 4));
         chk("rot_data", 32'(out_data), 32'hA0 + 32'(i % 4));
      end

      // backpressure hold, then pop and reload on one edge
      out_ready = 1'b0;
      #1 chk("bp_ready", 32'(in_ready), 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         #1;
         chk("bp_sel", 32'(out_sel), 3);
         chk("bp_data", 32'(out_data), 32'hA3);
      end
      out_ready = 1'b1;
      cyc();
      #1;
      chk("pop_valid", 32'(out_valid), 1);
      chk("pop_sel", 32'(out_sel), 0);
      chk("pop_data", 32'(out_data), 32'hA0);

      // pointer wrap: grant ch2 to put ptr at 3, then ch0+ch3 compete
      rst = 1'b1;
      #1 rst = 1'b0;
      in_valid = 4'b0100;
      in_data  = {8'h33, 8'h55, 8'h00, 8'h11};
      cyc();
      in_valid = 4'b1001;
      #1 chk("wrap_a", 32'(out_sel), 2);
      cyc();
      in_valid = 4'b0001;
      #1;
      chk("wrap_b_sel", 32'(out_sel), 3);
      chk("wrap_b_data", 32'(out_data), 32'h33);
      cyc();
      in_valid = '0;
      #1;
      chk("wrap_c_sel", 32'(out_sel), 0);
      chk("wrap_c_data", 32'(out_data), 32'h11);

`ifdef RR_STREAM_MUX_LOCK_EN
      // packet lock: ch1 three-beat packet against continuously valid ch0
      rst = 1'b1;
      #1 rst = 1'b0;
      in_last  = '1;
      in_valid = 4'b0001;
      in_data  = {8'h00, 8'h00, 8'h21, 8'h10};
      cyc();
      in_valid   = 4'b0011;
      in_last[1] = 1'b0;
      cyc();
      in_data[W +: W] = 8'h22;
      #1 chk("lock_b1", {out_sel, out_last, out_data}, {2'd1, 1'b0, 8'h21});
      cyc();
      in_data[W +: W] = 8'h23;
      in_last[1] = 1'b1;
      #1 chk("lock_b2", {out_sel, out_last, out_data}, {2'd1, 1'b0, 8'h22});
      cyc();
      in_valid = 4'b0001;
      #1 chk("lock_b3", {out_sel, out_last, out_data}, {2'd1, 1'b1, 8'h23});
      cyc();
      in_valid = '0;
      #1 chk("lock_ch0", {out_sel, out_last, out_data}, {2'd0, 1'b1, 8'h10});
`endif

      // randomized traffic; data/last held until accepted
      for (int t = 0; t < 3000; t++) begin
         cyc();
         if (t == 1500) begin
            rst = 1'b1;
            #1 rst = 1'b0;
         end
         for (int c = 0; c < N; c++) begin
            if (!in_valid[c] || m_acc == c) begin
               in_valid[c] = ($urandom_range(0, 99) < 60);
               in_data[c*W +: W] = W'($urandom);
               in_last[c] = LOCK ? 1'($urandom) : 1'b1;
            end
         end
         out_ready = ($urandom_range(0, 99) < 70);
      end
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N:1 stream multiplexer; next generation of the gate-level 4:1 mux.
- Generalised in channel count and data width.
- Adds valid/ready handshakes on every input and on the output, fair round-robin arbitration, and a registered output stage.
- Sits between several producer streams and one shared consumer; the consumer is typically a FIFO or a serializer.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N), width of the granted-channel index (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i is bits [i*W +: W].
- in_ready  output  N  per-channel ready; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. Reset takes effect immediately, including mid-transfer. Any held word is discarded.
- load = ~out_valid | out_ready. The output register may capture a new word this cycle only when load is 1.
- Arbitration is combinational:
  - Scan channels ptr, ptr+1, ..., ptr+N-1 (mod N).
  - The first channel with in_valid=1 wins; grant is one-hot.
  - No valid input gives grant=0.
- in_ready = grant & {N{load}}. At most one in_ready bit is high per cycle. A channel's in_ready never rises unless that channel's in_valid is 1.
- Data select uses AND-OR masking: out_data_next = OR over i of (in_data[i] & {W{grant[i]}}). No priority-encoded case chain on the data path.
- On a clock edge with load=1 and any grant:
  - out_valid<=1, out_data<=selected word, out_sel<=granted index.
  - ptr<=(granted index+1) mod N.
- On a clock edge with load=1 and no grant: out_valid<=0. out_data, out_sel and ptr hold.
- On a clock edge with load=0: all registers hold (backpressure).
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... Each channel waits at most N-1 transfers.
- ptr wraps from N-1 to 0.
- Simultaneous pop and push (out_valid=1, out_ready=1, grant present) is a full-rate pass-through, with no bubble.
- Inputs must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro: RR_STREAM_MUX_LOCK_EN.
- When defined:
  - Adds input port in_last [N-1:0] and output port out_last [0:0], registered alongside out_data with reset value 0.
  - Once a channel is granted with in_last=0, the grant is locked to that channel. No other channel gets in_ready until a handshake on that channel with in_last=1.
  - ptr advances only on that final beat.
  - Reset clears the lock.
- When undefined: no in_last/out_last ports; arbitration is per word as above.

Test Plan:
- N=4, W=8. Reset asserted with out_valid=1 mid-stream -> out_valid, out_data, out_sel, ptr go to 0 immediately, without waiting for a clk edge.
- Only ch2 valid, in_data[2]=8'hC3, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=C3, out_sel=2.
- All channels valid with data 8'hA0..8'hA3, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data matches A0..A3; no idle cycles.
- out_ready=0 with out_valid=1 -> in_ready=0, and out_data, out_sel and ptr hold for 5 cycles. out_ready=1 -> the held word pops and the next grant loads on the same edge.
- ptr=3, ch0 and ch3 valid -> ch3 granted first, then ch0, showing wrap-around.
- With RR_STREAM_MUX_LOCK_EN: ch1 sends 3 beats with in_last on beat 3 while ch0 is continuously valid -> out_sel=1,1,1, then 0; out_last=1 only on the third beat.
